sort_controller: RTL and testbench

//  Sequencer that bubble-sorts a block of DEPTH unsigned N-bit words using ONE shared

---
 rtl/sort_controller.sv | 189 ++++++++++++++++++
 tb/tb_sort_controller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_controller.sv
// ----------------------------------------------------------------------------
// sort_controller
//   Loads a block of DEPTH unsigned N-bit words serially, bubble-sorts them in
//   place with a single shared comparator (one compare per clock), then
//   streams the words out in ascending order, one per clock.
//
//   Handshake rules:
//     start is sampled only while ready=1 (IDLE). din is written only on
//     cycles with din_valid=1 while loading. dout is valid on each cycle with
//     dout_valid=1; there is no backpressure. done pulses together with the
//     last dout_valid of a block.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous, active-high reset
//   start      in   1   begin a block (IDLE only)
//   din_valid  in   1   din carries a word (LOAD only)
//   din        in   N   input word
//   ready      out  1   high while IDLE
//   busy       out  1   high in LOAD, SORT and OUT
//   dout_valid out  1   dout carries a sorted word
//   dout       out  N   sorted word, ascending unsigned
//   done       out  1   pulse with the last sorted word
//   swap_cnt   out  SW  swaps made in the current/last block
// ----------------------------------------------------------------------------

module comparator #(
    parameter int N = 16
) (
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    output logic         lt
);
    assign lt = (in1 < in2);
endmodule

module sort_controller #(
    parameter int N     = 16,
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH),
    localparam int SW   = $clog2(DEPTH*(DEPTH-1)/2+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          din_valid,
    input  logic [N-1:0]  din,
    output logic          ready,
    output logic          busy,
    output logic          dout_valid,
    output logic [N-1:0]  dout,
    output logic          done,
    output logic [SW-1:0] swap_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SORT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST_IDX  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] LAST_PASS = CW'(DEPTH - 2);

    state_t        state;
    state_t        state_nxt;

    logic [N-1:0]  mem [DEPTH];
    logic [CW-1:0] idx;      // load write pointer
    logic [CW-1:0] i;        // compare position within a pass
    logic [CW-1:0] p;        // pass number
    logic [CW-1:0] k;        // output read pointer
    logic          flag;     // a swap happened earlier in this pass

    logic [CW-1:0] i_p1;
    logic [N-1:0]  cmp_in1;
    logic [N-1:0]  cmp_in2;
    logic          lt;

    logic          load_last;
    logic          pass_end;
    logic          sort_exit;
    logic          out_last;

    assign i_p1    = i + CW'(1);
    assign cmp_in1 = mem[i_p1];
    assign cmp_in2 = mem[i];

    comparator #(.N(N)) u_cmp (
        .in1 (cmp_in1),
        .in2 (cmp_in2),
        .lt  (lt)
    );

    assign load_last = (state == S_LOAD) && din_valid && (idx == LAST_IDX);
    // Each pass shrinks by one: the largest remaining word has bubbled to the top.
    assign pass_end  = (i == (LAST_PASS - p));
    // A pass with no swaps (including this cycle's compare) means the block is sorted.
    assign sort_exit = pass_end && (!(flag || lt) || (p == LAST_PASS));
    assign out_last  = (state == S_OUT) && (k == LAST_IDX);

    assign ready = (state == S_IDLE);
    assign busy  = (state != S_IDLE);

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start)     state_nxt = S_LOAD;
            S_LOAD: if (load_last) state_nxt = S_SORT;
            S_SORT: if (sort_exit) state_nxt = S_OUT;
            S_OUT:  if (out_last)  state_nxt = S_IDLE;
            default:               state_nxt = S_IDLE;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            i          <= '0;
            p          <= '0;
            k          <= '0;
            flag       <= 1'b0;
            swap_cnt   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            dout_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx      <= '0;
                        swap_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (din_valid) begin
                        if (idx == LAST_IDX) begin
                            i    <= '0;
                            p    <= '0;
                            flag <= 1'b0;
                        end else begin
                            idx <= idx + CW'(1);
                        end
                    end
                end
                S_SORT: begin
                    if (lt) swap_cnt <= swap_cnt + SW'(1);
                    if (pass_end) begin
                        if (sort_exit) begin
                            k <= '0;
                        end else begin
                            p    <= p + CW'(1);
                            i    <= '0;
                            flag <= 1'b0;
                        end
                    end else begin
                        i    <= i_p1;
                        flag <= flag | lt;
                    end
                end
                S_OUT: begin
                    dout       <= mem[k];
                    dout_valid <= 1'b1;
                    if (k == LAST_IDX) done <= 1'b1;
                    else               k    <= k + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Word storage: contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if ((state == S_LOAD) && din_valid) begin
            mem[idx] <= din;
        end else if ((state == S_SORT) && lt) begin
            mem[i]    <= mem[i_p1];
            mem[i_p1] <= mem[i];
        end
    end

endmodule

// File: tb/tb_sort_controller.sv
module tb_sort_controller;
  localparam int N     = 16;
  localparam int DEPTH = 8;
  localparam int SW    = $clog2(DEPTH*(DEPTH-1)/2+1);

  typedef logic [N-1:0] block_t [DEPTH];

  logic          clk;
  logic          rst;
  logic          start;
  logic          din_valid;
  logic [N-1:0]  din;
  logic          ready;
  logic          busy;
  logic          dout_valid;
  logic [N-1:0]  dout;
  logic          done;
  logic [SW-1:0] swap_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // {done expected, word}
  logic [N:0]    exp_q[$];
  logic [SW-1:0] exp_swap_q[$];

  sort_controller #(.N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .din_valid  (din_valid),
    .din        (din),
    .ready      (ready),
    .busy       (busy),
    .dout_valid (dout_valid),
    .dout       (dout),
    .done       (done),
    .swap_cnt   (swap_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // reference model
  function automatic int model_swaps(input block_t w);
    int inv = 0;
    for (int a = 0; a < DEPTH; a++)
      for (int b = a + 1; b < DEPTH; b++)
        if (w[a] > w[b]) inv++;
    return inv;
  endfunction

  function automatic int model_sort_cycles(input block_t w);
    logic [N-1:0] a [DEPTH];
    logic [N-1:0] t;
    int cyc = 0;
    bit any;
    a = w;
    for (int ps = 0; ps < DEPTH - 1; ps++) begin
      any = 0;
      for (int j = 0; j < DEPTH - 1 - ps; j++) begin
        cyc++;
        if (a[j+1] < a[j]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t; any = 1;
        end
      end
      if (!any) break;
    end
    return cyc;
  endfunction

  task automatic push_expect(input block_t w);
    logic [N-1:0] q[$];
    for (int j = 0; j < DEPTH; j++) q.push_back(w[j]);
    q.sort();
    for (int j = 0; j < DEPTH; j++) exp_q.push_back({(j == DEPTH - 1), q[j]});
    exp_swap_q.push_back(SW'(model_swaps(w)));
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_dout: got %0h, expected no output", dout);
        end else begin
          logic [N:0] e;
          e = exp_q.pop_front();
          check("dout", 32'(dout), 32'(e[N-1:0]));
          check("done_flag", 32'(done), 32'(e[N]));
        end
        if (done) begin
          if (exp_swap_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL swap_cnt_unexpected: got %0d, expected no block end", swap_cnt);
          end else begin
            check("swap_cnt", 32'(swap_cnt), 32'(exp_swap_q.pop_front()));
          end
        end
      end else if (done) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_without_valid: got 1, expected 0");
      end
    end
  end

  // driver tasks
  task automatic load_block(input block_t w, input int stall_at, input int stall_len,
                            input bit skip_start);
    if (!skip_start) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("ready_after_start", 32'(ready), 32'd0);
    check("swap_cnt_cleared", 32'(swap_cnt), 32'd0);
    for (int j = 0; j < DEPTH; j++) begin
      if (j == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          din_valid = 1'b0;
          din = N'($urandom);
          @(negedge clk);
        end
      end
      din_valid = 1'b1;
      din = w[j];
      @(negedge clk);
    end
    din_valid = 1'b0;
    din = N'($urandom);
  endtask

  task automatic finish_block(input block_t w, input bit noise, input bit b2b);
    int cycles = 0;
    int words  = 0;
    push_expect(w);
    while (!dout_valid && cycles < 300) begin
      if (noise) start = 1'($urandom_range(0, 1));
      cycles++;
      @(negedge clk);
    end
    check("sort_cycles", 32'(cycles - 1), 32'(model_sort_cycles(w)));
    while (!done && words < DEPTH + 4) begin
      check("dout_consecutive", 32'(dout_valid), 32'd1);
      if (noise) start = 1'($urandom_range(0, 1));
      words++;
      @(negedge clk);
    end
    check("done_position", 32'(words), 32'(DEPTH - 1));
    start = b2b;
    if (!b2b) begin
      @(negedge clk);
      check("idle_ready", 32'(ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("swap_cnt_hold", 32'(swap_cnt), 32'(model_swaps(w)));
      @(negedge clk);
      check("idle_stays", 32'(ready), 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
    check({tag, "_dout"}, 32'(dout), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_swap_cnt"}, 32'(swap_cnt), 32'd0);
  endtask

  block_t w;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    din_valid = 1'b0;
    din = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // reverse order: worst case
    w = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    load_block(w, -1, 0, 1'b0);
    finish_block(w, 1'b0, 1'b0);

    // already sorted: early exit
    w = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    load_block(w, -1, 0, 1'b0);
    finish_block(w, 1'b0, 1'b0);

    // unsigned extremes and duplicates
    w = '{16'hFFFF, 16'h0000, 16'h0005, 16'h0005, 16'h8000, 16'h0001, 16'h7FFF, 16'h0005};
    load_block(w, -1, 0, 1'b0);
    finish_block(w, 1'b0, 1'b0);

    // stall mid-load, start noise during SORT and OUT
    w = '{16'd30, 16'd10, 16'd50, 16'd20, 16'd70, 16'd40, 16'd60, 16'd0};
    load_block(w, 3, 3, 1'b0);
    finish_block(w, 1'b1, 1'b0);

    // reset during SORT after 5 compares
    w = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    load_block(w, -1, 0, 1'b0);
    repeat (5) @(negedge clk);
    check("swap_cnt_before_abort", 32'(swap_cnt), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    w = '{16'd2, 16'd1, 16'd4, 16'd3, 16'd6, 16'd5, 16'd8, 16'd7};
    load_block(w, -1, 0, 1'b0);
    finish_block(w, 1'b0, 1'b0);

    // back-to-back blocks: start on the first ready cycle
    w = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    load_block(w, -1, 0, 1'b0);
    finish_block(w, 1'b0, 1'b1);
    w = '{16'd5, 16'd3, 16'd9, 16'd1, 16'd9, 16'd2, 16'd0, 16'd4};
    load_block(w, -1, 0, 1'b1);
    finish_block(w, 1'b0, 1'b0);

    // randomized blocks
    for (int b = 0; b < 12; b++) begin
      for (int j = 0; j < DEPTH; j++)
        w[j] = (b % 2 == 0) ? N'($urandom) : N'($urandom_range(0, 7));
      load_block(w, $urandom_range(0, DEPTH), $urandom_range(0, 3), 1'b0);
      finish_block(w, 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
